// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage ahead of decode. Holds the PC and issues word fetches over a
// valid/ready request channel. Responses return in request order. Fetched
// words are buffered together with their PCs and handed to decode over a
// valid/ready output channel. A redirect flushes the buffer and marks every
// in-flight fetch as stale, so that its response is dropped when it arrives.
//
// Ports
//   clk              clock; all state updates on the rising edge
//   rst              synchronous, active-high reset
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts the request
//   imem_req_addr    fetch address (always the current PC, word aligned)
//   imem_resp_valid  response valid (in request order)
//   imem_resp_data   fetched instruction word
//   redirect_valid   one-cycle redirect pulse from execute
//   redirect_pc      redirect target (low two bits are ignored)
//   out_valid        instruction available to decode
//   out_ready        decode consumes the instruction
//   out_instr        instruction word
//   out_pc           PC of out_instr
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

   // Architectural state
   logic [63:0]   pc_reg;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] inflight_reg;
   logic [CW-1:0] stale_reg;
   logic [AW-1:0] buf_head_reg;
   logic [AW-1:0] buf_tail_reg;
   logic [AW-1:0] pend_head_reg;
   logic [AW-1:0] pend_tail_reg;
   logic [31:0]   last_instr_reg;
   logic [63:0]   last_pc_reg;

   // Storage (no reset needed; validity is tracked by the counters)
   logic [31:0]   buf_instr [DEPTH];
   logic [63:0]   buf_pc    [DEPTH];
   logic [63:0]   pend_pc   [DEPTH];

   logic [CW+1:0] occupancy;
   logic          credit_ok;
   logic          req_fire;
   logic          resp_stale;
   logic          resp_live;
   logic          push;
   logic          pop;
   logic          unused_bits;

   // Every slot that may still produce or hold an instruction consumes a
   // credit, including responses that will be thrown away.
   assign occupancy = (CW+2)'(inflight_reg) + (CW+2)'(stale_reg) + (CW+2)'(count_reg);
   assign credit_ok = occupancy < DEPTH_W;

   assign imem_req_valid = !rst && credit_ok && !redirect_valid;
   assign imem_req_addr  = pc_reg;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Stale responses are consumed first; a response with nothing
   // outstanding is ignored.
   assign resp_stale = imem_resp_valid && (stale_reg != '0);
   assign resp_live  = imem_resp_valid && (stale_reg == '0) && (inflight_reg != '0);
   assign push       = resp_live && !redirect_valid;

   assign out_valid = (count_reg != '0);
   assign pop       = out_valid && out_ready;
   // When empty, the last word presented to decode stays on the outputs.
   assign out_instr = out_valid ? buf_instr[buf_head_reg] : last_instr_reg;
   assign out_pc    = out_valid ? buf_pc[buf_head_reg]    : last_pc_reg;

   assign unused_bits = ^redirect_pc[1:0];

   // Data storage writes
   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr[buf_tail_reg] <= imem_resp_data;
         buf_pc[buf_tail_reg]    <= pend_pc[pend_head_reg];
      end
      if (req_fire) begin
         pend_pc[pend_tail_reg] <= pc_reg;
      end
   end

   // Control state
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg         <= RESET_PC;
         count_reg      <= '0;
         inflight_reg   <= '0;
         stale_reg      <= '0;
         buf_head_reg   <= '0;
         buf_tail_reg   <= '0;
         pend_head_reg  <= '0;
         pend_tail_reg  <= '0;
         last_instr_reg <= '0;
         last_pc_reg    <= '0;
      end else begin
         if (out_valid) begin
            last_instr_reg <= buf_instr[buf_head_reg];
            last_pc_reg    <= buf_pc[buf_head_reg];
         end
         if (redirect_valid) begin
            // Everything outstanding becomes stale, minus whichever response
            // lands in this very cycle (it is dropped here).
            pc_reg        <= {redirect_pc[63:2], 2'b00};
            count_reg     <= '0;
            buf_head_reg  <= '0;
            buf_tail_reg  <= '0;
            pend_head_reg <= '0;
            pend_tail_reg <= '0;
            inflight_reg  <= '0;
            stale_reg     <= stale_reg + inflight_reg - CW'(resp_live) - CW'(resp_stale);
         end else begin
            if (req_fire) begin
               pc_reg        <= pc_reg + 64'd4;
               pend_tail_reg <= pend_tail_reg + AW'(1);
            end
            if (resp_live) begin
               pend_head_reg <= pend_head_reg + AW'(1);
            end
            if (push) begin
               buf_tail_reg <= buf_tail_reg + AW'(1);
            end
            if (pop) begin
               buf_head_reg <= buf_head_reg + AW'(1);
            end
            count_reg    <= count_reg + CW'(push) - CW'(pop);
            inflight_reg <= inflight_reg + CW'(req_fire) - CW'(resp_live);
            stale_reg    <= stale_reg - CW'(resp_stale);
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// Directed and randomized-memory bench for instruction_fetch_unit.
// The memory model answers each accepted fetch in order after a configurable
// latency with data = address[31:0], and is cleared by rst.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

   localparam logic [63:0] RPC = 64'h1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;

   int vectors = 0;
   int miscompares = 0;

   // memory model controls
   int mem_lat = 1;
   bit mem_rand = 1'b0;

   always #5 clk = ~clk;

   instruction_fetch_unit #(.RESET_PC(RPC), .DEPTH(2)) dut (
      .clk(clk),
      .rst(rst),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc)
   );

   // In-order memory: handshakes sampled at the falling edge, state updated
   // just after the rising edge they refer to.
   logic [63:0] mq_addr [$];
   int          mq_due  [$];
   int          cyc = 0;

   initial begin
      logic        s_req;
      logic        s_resp;
      logic        s_rst;
      logic [63:0] s_addr;
      logic [63:0] head_addr;
      int          lat;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'd0;
      forever begin
         @(negedge clk);
         s_req  = imem_req_valid && imem_req_ready;
         s_addr = imem_req_addr;
         s_resp = imem_resp_valid;
         s_rst  = rst;
         @(posedge clk);
         #1;
         cyc++;
         if (s_rst) begin
            mq_addr.delete();
            mq_due.delete();
         end else begin
            if (s_resp) begin
               void'(mq_addr.pop_front());
               void'(mq_due.pop_front());
            end
            if (s_req) begin
               lat = mem_rand ? int'($urandom_range(1, 5)) : mem_lat;
               mq_addr.push_back(s_addr);
               mq_due.push_back(cyc + lat - 1);
            end
         end
         if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            head_addr       = mq_addr[0];
            imem_resp_valid = 1'b1;
            imem_resp_data  = head_addr[31:0];
         end else begin
            imem_resp_valid = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc_wait();
      @(posedge clk);
      #2;
   endtask

   // Leaves the bench in the first cycle after reset release, inputs settled.
   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      cyc_wait();
      cyc_wait();
      rst = 1'b0;
      #1;
   endtask

   // Waits (bounded) for out_valid, checks the word, consumes it (out_ready=1).
   task automatic wait_deliver(input string tag, input logic [63:0] exp_pc);
      int n = 0;
      while (!out_valid && n < 40) begin
         cyc_wait();
         n++;
      end
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_pc"}, out_pc, exp_pc);
      chk({tag, "_instr"}, 64'(out_instr), {32'd0, exp_pc[31:0]});
      cyc_wait();
   endtask

   initial begin
      logic [63:0] exp_pc;
      int got;
      int n;

      rst = 1'b1;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 64'd0;
      out_ready = 1'b1;

      // ---- reset values
      cyc_wait();
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_req_addr", imem_req_addr, RPC);

      // ---- zero-wait streaming
      mem_lat = 1;
      do_reset();
      chk("c0_req_valid", 64'(imem_req_valid), 64'd1);
      chk("c0_req_addr", imem_req_addr, RPC);
      chk("c0_out_valid", 64'(out_valid), 64'd0);
      cyc_wait();
      chk("c1_out_valid", 64'(out_valid), 64'd0);
      cyc_wait();
      chk("c2_out_valid", 64'(out_valid), 64'd1);
      wait_deliver("seq0", 64'h1000);
      wait_deliver("seq1", 64'h1004);
      wait_deliver("seq2", 64'h1008);
      wait_deliver("seq3", 64'h100c);

      // ---- backpressure
      out_ready = 1'b0;
      do_reset();
      repeat (10) cyc_wait();
      chk("bp_full_valid", 64'(out_valid), 64'd1);
      chk("bp_full_pc", out_pc, 64'h1000);
      chk("bp_full_req_valid", 64'(imem_req_valid), 64'd0);
      out_ready = 1'b1;
      #1;
      chk("bp_head_instr", 64'(out_instr), 64'h1000);
      cyc_wait();
      chk("bp_second_pc", out_pc, 64'h1004);
      chk("bp_second_valid", 64'(out_valid), 64'd1);
      chk("bp_refill_req_valid", 64'(imem_req_valid), 64'd1);
      chk("bp_refill_addr", imem_req_addr, 64'h1008);
      cyc_wait();
      chk("bp_empty_valid", 64'(out_valid), 64'd0);
      chk("bp_hold_pc", out_pc, 64'h1004);

      // ---- redirect with one buffered and one in flight
      out_ready = 1'b0;
      mem_lat = 3;
      do_reset();
      cyc_wait();
      imem_req_ready = 1'b0;
      cyc_wait();
      imem_req_ready = 1'b1;
      #1;
      chk("rd_req2_addr", imem_req_addr, 64'h1004);
      cyc_wait();
      cyc_wait();
      chk("rd_buffered_pc", out_pc, 64'h1000);
      chk("rd_no_resp", 64'(imem_resp_valid), 64'd0);
      redirect_valid = 1'b1;
      redirect_pc = 64'h2002;
      #1;
      chk("rd_cycle_req_valid", 64'(imem_req_valid), 64'd0);
      cyc_wait();
      redirect_valid = 1'b0;
      #1;
      chk("rd_flush_valid", 64'(out_valid), 64'd0);
      chk("rd_new_addr", imem_req_addr, 64'h2000);
      chk("rd_new_req_valid", 64'(imem_req_valid), 64'd1);
      out_ready = 1'b1;
      wait_deliver("rd_first", 64'h2000);
      wait_deliver("rd_second", 64'h2004);

      // ---- redirect colliding with a live response and a decode pop
      out_ready = 1'b1;
      mem_lat = 1;
      do_reset();
      cyc_wait();
      cyc_wait();
      chk("col_pop_valid", 64'(out_valid), 64'd1);
      chk("col_pop_pc", out_pc, 64'h1000);
      chk("col_resp_arrives", 64'(imem_resp_valid), 64'd1);
      redirect_valid = 1'b1;
      redirect_pc = 64'h3000;
      cyc_wait();
      redirect_valid = 1'b0;
      #1;
      chk("col_flush_valid", 64'(out_valid), 64'd0);
      chk("col_req_valid", 64'(imem_req_valid), 64'd1);
      chk("col_req_addr", imem_req_addr, 64'h3000);
      wait_deliver("col_first", 64'h3000);
      wait_deliver("col_second", 64'h3004);
      wait_deliver("col_third", 64'h3008);

      // ---- random latency and handshakes
      mem_rand = 1'b1;
      do_reset();
      exp_pc = RPC;
      got = 0;
      for (int c = 0; c < 30000 && got < 1000; c++) begin
         imem_req_ready = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            chk("rand_pc", out_pc, exp_pc);
            chk("rand_instr", 64'(out_instr), {32'd0, exp_pc[31:0]});
            exp_pc = exp_pc + 64'd4;
            got++;
         end
         cyc_wait();
      end
      chk("rand_count", 64'(got), 64'd1000);

      // ---- reset with two fetches in flight, then PC wrap
      mem_rand = 1'b0;
      mem_lat = 3;
      imem_req_ready = 1'b1;
      out_ready = 1'b1;
      do_reset();
      repeat (5) cyc_wait();
      chk("mr_c5_pc", out_pc, 64'h1004);
      cyc_wait();
      chk("mr_c6_valid", 64'(out_valid), 64'd0);
      chk("mr_c6_hold_pc", out_pc, 64'h1004);
      chk("mr_c6_hold_instr", 64'(out_instr), 64'h1004);
      cyc_wait();
      rst = 1'b1;
      #1;
      chk("mr_rst_req_valid", 64'(imem_req_valid), 64'd0);
      cyc_wait();
      chk("mr_out_valid", 64'(out_valid), 64'd0);
      chk("mr_out_pc", out_pc, 64'd0);
      chk("mr_out_instr", 64'(out_instr), 64'd0);
      chk("mr_req_addr", imem_req_addr, RPC);
      rst = 1'b0;
      #1;
      chk("mr_restart_req", 64'(imem_req_valid), 64'd1);
      wait_deliver("mr_first", RPC);

      redirect_valid = 1'b1;
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
      cyc_wait();
      redirect_valid = 1'b0;
      #1;
      chk("wrap_aligned_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      n = 0;
      while (!imem_req_valid && n < 20) begin
         cyc_wait();
         n++;
      end
      chk("wrap_req_valid", 64'(imem_req_valid), 64'd1);
      cyc_wait();
      chk("wrap_next_addr", imem_req_addr, 64'd0);
      wait_deliver("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC);
      wait_deliver("wrap_zero", 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
